// File: rtl/i2c_multi_read_seq_pkg.sv
// i2c_multi_read_seq_pkg
//   Shared definitions for the multi-channel I2C read sequencer:
//   FSM state encoding, I2C direction constant, byte width and the
//   width of the per-wait timeout counter.
package i2c_multi_read_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_REQ     = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_FINISH  = 3'd6
  } state_e;

  localparam logic I2C_RW_READ = 1'b1;
  localparam int   BYTE_W      = 8;
  localparam int   TMR_W       = 16;

  // True for every state that is waiting on the I2C master.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_REQ) || (s == ST_WAIT_HI) || (s == ST_WAIT_LO) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/i2c_multi_read_seq_wait_timer.sv
// i2c_wait_timer
//   Busy edge detector plus a saturating timeout counter.
//   Ports:
//     clk_i, rst_ni  clock, asynchronous active-low reset
//     busy_i         busy flag from the I2C master
//     clear_i        restart the counter (caller is outside a wait or changing wait)
//     run_i          count while waiting
//     rise_o/fall_o  busy edge: registered busy compared with the live input
//     expired_o      counter has reached TIMEOUT
module i2c_wait_timer
  import i2c_multi_read_seq_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic busy_i,
  input  logic clear_i,
  input  logic run_i,
  output logic rise_o,
  output logic fall_o,
  output logic expired_o
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT);

  logic             busy_q;
  logic [TMR_W-1:0] cnt_q;

  assign rise_o    = ~busy_q & busy_i;
  assign fall_o    = busy_q & ~busy_i;
  assign expired_o = (cnt_q >= LIMIT);

  // Busy history register and per-edge timeout counter; any edge restarts the wait.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= {TMR_W{1'b0}};
    end else begin
      busy_q <= busy_i;
      if (clear_i || rise_o || fall_o) begin
        cnt_q <= {TMR_W{1'b0}};
      end else if (run_i && (cnt_q < LIMIT)) begin
        cnt_q <= cnt_q + 16'd1;
      end else begin
        cnt_q <= cnt_q;
      end
    end
  end

endmodule

// File: rtl/i2c_multi_read_seq.sv
// i2c_multi_read_seq
//   Scans up to NUM_CH I2C sensors in ascending index order, reading NBYTES
//   bytes from each in a single read transaction through a byte-level master.
//   Ports:
//     clk_i, rst_ni             clock, asynchronous active-low reset
//     start_i, ch_mask_i        start a scan over the enabled channels (IDLE only)
//     ready_o                   high while idle
//     rd_valid_o/rd_ch_o/rd_data_o  one-cycle result strobe per completed channel,
//                               first received byte in the MSBs
//     done_o                    one-cycle strobe at end of scan
//     err_o/err_ch_o            sticky error (NACK or timeout) and first failing channel
//     addr_o/rw_o/ena_o         request side of the I2C master
//     busy_i/data_rd_i/ack_error_i  status side of the I2C master
module i2c_multi_read_seq
  import i2c_multi_read_seq_pkg::*;
#(
  parameter int                  NUM_CH     = 2,
  parameter int                  NBYTES     = 2,
  parameter logic [7*NUM_CH-1:0] ADDR_TABLE = {7'h39, 7'h38},
  parameter int                  TIMEOUT    = 50000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [NUM_CH-1:0]          ch_mask_i,
  output logic                       ready_o,
  output logic                       rd_valid_o,
  output logic [2:0]                 rd_ch_o,
  output logic [BYTE_W*NBYTES-1:0]   rd_data_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [2:0]                 err_ch_o,
  output logic [6:0]                 addr_o,
  output logic                       rw_o,
  output logic                       ena_o,
  input  logic                       busy_i,
  input  logic [7:0]                 data_rd_i,
  input  logic                       ack_error_i
);

  localparam int DW = BYTE_W * NBYTES;

  state_e            state_q;
  logic [NUM_CH-1:0] mask_q;
  logic [3:0]        ch_q;
  logic [1:0]        k_q;
  logic [DW-1:0]     buf_q;

  logic              ready_q;
  logic              rd_valid_q;
  logic [2:0]        rd_ch_q;
  logic [DW-1:0]     rd_data_q;
  logic              done_q;
  logic              err_q;
  logic [2:0]        err_ch_q;
  logic [6:0]        addr_q;
  logic              rw_q;
  logic              ena_q;

  logic              rise_s;
  logic              fall_s;
  logic              expired_s;
  logic              in_wait_s;
  logic              ack_hit_s;
  logic              tmr_clear_s;
  logic              found_s;
  logic [3:0]        sel_ch_s;
  logic [6:0]        addr_sel_s;
  logic [DW-1:0]     shifted_s;
  logic              last_k_s;
  logic [3:0]        ch_inc_s;

  assign ready_o    = ready_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_ch_o    = rd_ch_q;
  assign rd_data_o  = rd_data_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_ch_o   = err_ch_q;
  assign addr_o     = addr_q;
  assign rw_o       = rw_q;
  assign ena_o      = ena_q;

  // A stale ack_error from the previous transaction may linger until the
  // master starts the next one, so it only counts after the first busy rise.
  assign in_wait_s   = is_wait_state(state_q);
  assign ack_hit_s   = ack_error_i && ((state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO));
  assign tmr_clear_s = ~in_wait_s | ack_hit_s;
  assign last_k_s    = (k_q == 2'(NBYTES - 1));
  assign ch_inc_s    = ch_q + 4'd1;

  i2c_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .busy_i    (busy_i),
    .clear_i   (tmr_clear_s),
    .run_i     (in_wait_s),
    .rise_o    (rise_s),
    .fall_o    (fall_s),
    .expired_o (expired_s)
  );

  // Lowest enabled channel at or above the current index, with its address.
  always_comb begin
    found_s    = 1'b0;
    sel_ch_s   = 4'd0;
    addr_sel_s = 7'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (4'(i) >= ch_q)) begin
        found_s    = 1'b1;
        sel_ch_s   = 4'(i);
        addr_sel_s = ADDR_TABLE[7*i +: 7];
      end else begin
        found_s    = found_s;
      end
    end
  end

  // Byte accumulator: earlier bytes shift up so the first byte ends in the MSBs.
  always_comb begin
    shifted_s               = buf_q << BYTE_W;
    shifted_s[BYTE_W-1:0]   = data_rd_i;
  end

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      mask_q     <= {NUM_CH{1'b0}};
      ch_q       <= 4'd0;
      k_q        <= 2'd0;
      buf_q      <= {DW{1'b0}};
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_ch_q    <= 3'd0;
      rd_data_q  <= {DW{1'b0}};
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_ch_q   <= 3'd0;
      addr_q     <= 7'd0;
      rw_q       <= 1'b0;
      ena_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mask_q   <= ch_mask_i;
            err_q    <= 1'b0;
            err_ch_q <= 3'd0;
            ch_q     <= 4'd0;
            ready_q  <= 1'b0;
            state_q  <= (ch_mask_i == {NUM_CH{1'b0}}) ? ST_FINISH : ST_SELECT;
          end else begin
            ready_q  <= 1'b1;
          end
        end

        ST_SELECT: begin
          if (found_s) begin
            ch_q    <= sel_ch_s;
            addr_q  <= addr_sel_s;
            rw_q    <= I2C_RW_READ;
            ena_q   <= 1'b1;
            k_q     <= 2'd0;
            state_q <= ST_REQ;
          end else begin
            state_q <= ST_FINISH;
          end
        end

        // Each rise starts a new byte and exposes the previous one on data_rd.
        ST_REQ, ST_WAIT_HI: begin
          if (ack_hit_s) begin
            err_q   <= 1'b1;
            if (!err_q) err_ch_q <= ch_q[2:0];
            ena_q   <= 1'b0;
            state_q <= ST_DRAIN;
          end else if (rise_s) begin
            if (k_q != 2'd0) buf_q <= shifted_s;
            if (last_k_s) begin
              ena_q   <= 1'b0;
              state_q <= ST_WAIT_LO;
            end else begin
              k_q     <= k_q + 2'd1;
              state_q <= ST_WAIT_HI;
            end
          end else if (expired_s) begin
            err_q   <= 1'b1;
            if (!err_q) err_ch_q <= ch_q[2:0];
            ena_q   <= 1'b0;
            ch_q    <= ch_inc_s;
            state_q <= ST_SELECT;
          end
        end

        ST_WAIT_LO: begin
          if (ack_hit_s) begin
            err_q   <= 1'b1;
            if (!err_q) err_ch_q <= ch_q[2:0];
            ena_q   <= 1'b0;
            state_q <= ST_DRAIN;
          end else if (fall_s) begin
            rd_data_q  <= shifted_s;
            rd_valid_q <= 1'b1;
            rd_ch_q    <= ch_q[2:0];
            ch_q       <= ch_inc_s;
            state_q    <= ST_SELECT;
          end else if (expired_s) begin
            err_q   <= 1'b1;
            if (!err_q) err_ch_q <= ch_q[2:0];
            ena_q   <= 1'b0;
            ch_q    <= ch_inc_s;
            state_q <= ST_SELECT;
          end
        end

        // After a NACK let the master finish its byte before the next channel.
        ST_DRAIN: begin
          if (!busy_i || expired_s) begin
            ch_q    <= ch_inc_s;
            state_q <= ST_SELECT;
          end
        end

        ST_FINISH: begin
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end

        default: begin
          ena_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
